spi_cmd_decoder: RTL and testbench

Byte-level command decoder that sits directly downstream of the synchronous SPI slave. It consumes received bytes (`mosi_byte`/`data_valid`) and the raw chip-select, and parses framed write/read bursts into 16-bit register-bus transactions. It also drives `miso_byte`, the next byte to be shifted out. It is the only path from the host MCU into the DSP engine's control registers.

---
 rtl/spi_cmd_decoder_if.sv | 25 ++
 rtl/spi_cmd_decoder.sv | 123 ++++++++++++
 tb/tb_spi_cmd_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-bus signals of the SPI command decoder.
// master = host/test side, slave = decoder side.
interface spi_cmd_decoder_if;
    logic        cs;
    logic [7:0]  mosi_byte;
    logic        data_valid;
    logic [7:0]  miso_byte;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output cs, mosi_byte, data_valid, rd_data,
        input  miso_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, err_count
    );
    modport slave (
        input  cs, mosi_byte, data_valid, rd_data,
        output miso_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, err_count
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Parses framed SPI write/read bursts into 16-bit register-bus transactions
// and supplies the read-back bytes for the MISO shifter.
module spi_cmd_decoder #(
    parameter logic [7:0] OPC_WRITE = 8'h01,
    parameter logic [7:0] OPC_READ  = 8'h02
) (
    input  logic             clk,
    input  logic             reset,
    spi_cmd_decoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, W_ADDR, W_HI, W_LO, R_ADDR, R_HI, R_LO, DISCARD} state_t;

    state_t      state, state_nx;
    logic        cs_meta, cs_s;
    logic [7:0]  addr, addr_nx, hi, hi_nx;
    logic [7:0]  lo_q, miso_q;
    logic        wr_fire, rd_fire, err_fire;
    logic        wr_en_q, frame_err_q;
    logic [7:0]  wr_addr_q, rd_addr_q, err_cnt_q;
    logic [15:0] wr_data_q;
    // [0] = rd_en, [1] = rd_data capture cycle
    logic [1:0]  vld_pipe;

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        hi_nx    = hi;
        wr_fire  = 1'b0;
        rd_fire  = 1'b0;
        err_fire = 1'b0;
        if (cs_s) begin
            // Deselect wins over a coincident byte; judge the pre-byte state.
            state_nx = IDLE;
            if (state inside {W_ADDR, R_ADDR, W_LO}) err_fire = 1'b1;
        end else if (bus.data_valid) begin
            case (state)
                IDLE: begin
                    if (bus.mosi_byte == OPC_WRITE)     state_nx = W_ADDR;
                    else if (bus.mosi_byte == OPC_READ) state_nx = R_ADDR;
                    else begin
                        state_nx = DISCARD;
                        err_fire = 1'b1;
                    end
                end
                W_ADDR: begin
                    addr_nx  = bus.mosi_byte;
                    state_nx = W_HI;
                end
                W_HI: begin
                    hi_nx    = bus.mosi_byte;
                    state_nx = W_LO;
                end
                W_LO: begin
                    wr_fire  = 1'b1;
                    addr_nx  = addr + 8'd1;
                    state_nx = W_HI;
                end
                R_ADDR: begin
                    addr_nx  = bus.mosi_byte;
                    rd_fire  = 1'b1;
                    state_nx = R_HI;
                end
                R_HI: state_nx = R_LO;
                R_LO: begin
                    addr_nx  = addr + 8'd1;
                    rd_fire  = 1'b1;
                    state_nx = R_HI;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cs_meta     <= 1'b1;
            cs_s        <= 1'b1;
            addr        <= '0;
            hi          <= '0;
            lo_q        <= '0;
            miso_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            vld_pipe    <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cs_meta     <= bus.cs;
            cs_s        <= cs_meta;
            state       <= state_nx;
            addr        <= addr_nx;
            hi          <= hi_nx;
            wr_en_q     <= wr_fire;
            vld_pipe    <= {vld_pipe[0], rd_fire};
            frame_err_q <= err_fire;
            if (wr_fire) begin
                wr_addr_q <= addr;
                wr_data_q <= {hi, bus.mosi_byte};
            end
            if (rd_fire) rd_addr_q <= addr_nx;
            if (err_fire && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (state_nx == IDLE) miso_q <= '0;
            else if (vld_pipe[1]) begin
                miso_q <= bus.rd_data[15:8];
                lo_q   <= bus.rd_data[7:0];
            end else if (!cs_s && bus.data_valid && state == R_HI) miso_q <= lo_q;
        end
    end

    // The hi byte is forwarded straight from rd_data in its capture cycle,
    // then held from miso_q.
    assign bus.miso_byte = (vld_pipe[1] && state != IDLE) ? bus.rd_data[15:8] : miso_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_en     = vld_pipe[0];
    assign bus.rd_addr   = rd_addr_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames plus random bursts
// checked against a frame-level model of the command protocol.
module tb_spi_cmd_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_cmd_decoder_if bus ();
    spi_cmd_decoder dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;

    int n_cmp = 0;
    int n_fail = 0;
    int err_model = 0;

    // Register-bus stub: registered read port returning {addr, addr ^ mask}.
    logic [7:0]  rd_mask = 8'h00;
    logic [15:0] rd_reg = 16'h0000;
    assign bus.rd_data = rd_reg;
    always @(posedge clk) if (bus.rd_en) rd_reg <= {bus.rd_addr, bus.rd_addr ^ rd_mask};

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    always @(negedge clk) begin
        if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
        if (bus.rd_en) rd_q.push_back(bus.rd_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output logic w1, output logic r1, output logic e1,
                        output logic [7:0] m1, output logic [7:0] m2);
        bus.mosi_byte  = b;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        w1 = bus.wr_en;
        r1 = bus.rd_en;
        e1 = bus.frame_err;
        m1 = bus.miso_byte;
        @(negedge clk);
        m2 = bus.miso_byte;
        repeat (3) @(negedge clk);
    endtask

    task automatic bump_err();
        err_model = (err_model >= 255) ? 255 : err_model + 1;
    endtask

    // One complete frame: cs low, bytes, cs high; checked against the protocol rules.
    task automatic run_frame(input logic [7:0] fr[$]);
        wr_t        ew[$];
        logic [7:0] er[$];
        int         wb, rb, sz;
        logic       isw, isr, inc, bad, w1, r1, e1, odd;
        logic [7:0] m1, m2, a;
        sz  = fr.size();
        isw = sz > 0 && fr[0] == 8'h01;
        isr = sz > 0 && fr[0] == 8'h02;
        bad = sz > 0 && !isw && !isr;
        inc = (isw && (sz % 2 == 1)) || (isr && sz == 1);
        if (isw) for (int i = 3; i < sz; i += 2) ew.push_back({fr[1] + 8'((i - 3) / 2), fr[i-1], fr[i]});
        if (isr && sz > 1) for (int j = 0; j <= (sz - 2) / 2; j++) er.push_back(fr[1] + 8'(j));
        wb = wr_q.size();
        rb = rd_q.size();
        bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < sz; i++) begin
            send(fr[i], w1, r1, e1, m1, m2);
            odd = (i % 2 == 1);
            chk("wr_en_timing", 32'(w1), 32'(isw && i >= 3 && odd));
            chk("rd_en_timing", 32'(r1), 32'(isr && (i == 1 || (i >= 3 && odd))));
            chk("bad_opc_err", 32'(e1), 32'(bad && i == 0));
            if (isr && (i == 1 || (i >= 3 && odd))) begin
                a = fr[1] + 8'((i - 1) / 2);
                chk("miso_hi", 32'(m2), 32'(a));
            end
            if (isr && i >= 2 && !odd) begin
                a = fr[1] + 8'((i - 2) / 2);
                chk("miso_lo", 32'(m1), 32'(a ^ rd_mask));
            end
        end
        bus.cs = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("frame_end_err", 32'(bus.frame_err), 32'(k == 2 && inc));
        end
        repeat (2) @(negedge clk);
        if (inc || bad) bump_err();
        chk("miso_idle", 32'(bus.miso_byte), 32'h0);
        chk("err_count", 32'(bus.err_count), 32'(err_model));
        chk("wr_count", 32'(wr_q.size() - wb), 32'(ew.size()));
        for (int i = 0; i < ew.size() && wb + i < wr_q.size(); i++) begin
            chk("wr_addr", 32'(wr_q[wb+i].a), 32'(ew[i].a));
            chk("wr_data", 32'(wr_q[wb+i].d), 32'(ew[i].d));
        end
        chk("rd_count", 32'(rd_q.size() - rb), 32'(er.size()));
        for (int i = 0; i < er.size() && rb + i < rd_q.size(); i++)
            chk("rd_addr", 32'(rd_q[rb+i]), 32'(er[i]));
    endtask

    logic [7:0] q[$];
    logic       w1, r1, e1;
    logic [7:0] m1, m2;
    int         wb, len;

    initial begin
        bus.cs = 1'b1;
        bus.mosi_byte = 8'h00;
        bus.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_rd_en", 32'(bus.rd_en), 32'h0);
        chk("rst_miso", 32'(bus.miso_byte), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_err_count", 32'(bus.err_count), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        q = '{8'h01, 8'h10, 8'hAB, 8'hCD, 8'h12, 8'h34};
        run_frame(q);
        q = '{8'h02, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(q);
        q = '{8'h7E, 8'h01, 8'h10, 8'h20};
        run_frame(q);
        q = '{8'h01, 8'h05, 8'h00, 8'h01};
        run_frame(q);
        q = '{8'h01, 8'h20, 8'h99};
        run_frame(q);
        q = '{8'h02};
        run_frame(q);

        rd_mask = 8'h5A;
        for (int f = 0; f < 30; f++) begin
            q.delete();
            case ($urandom_range(0, 2))
                0: begin q.push_back(8'h01); len = $urandom_range(0, 7); end
                1: begin q.push_back(8'h02); len = $urandom_range(0, 6); end
                default: begin q.push_back(8'($urandom_range(3, 255))); len = $urandom_range(0, 3); end
            endcase
            repeat (len) q.push_back(8'($urandom));
            run_frame(q);
        end

        // Reset in W_LO: nothing committed, byte after release falls in the
        // cs-synchroniser window and is dropped.
        bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h01, w1, r1, e1, m1, m2);
        send(8'h30, w1, r1, e1, m1, m2);
        send(8'h55, w1, r1, e1, m1, m2);
        wb = wr_q.size();
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("midrst_wr_data", 32'(bus.wr_data), 32'h0);
        chk("midrst_miso", 32'(bus.miso_byte), 32'h0);
        chk("midrst_err_count", 32'(bus.err_count), 32'h0);
        err_model = 0;
        @(negedge clk);
        reset = 1'b0;
        send(8'h66, w1, r1, e1, m1, m2);
        chk("midrst_no_wr", 32'(w1), 32'h0);
        chk("midrst_no_err", 32'(e1), 32'h0);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_wr_count", 32'(wr_q.size() - wb), 32'h0);
        chk("midrst_err_after", 32'(bus.err_count), 32'h0);

        q = '{8'h7E};
        for (int f = 0; f < 256; f++) run_frame(q);
        chk("err_saturated", 32'(bus.err_count), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
